// File: rtl/bus_scenario_sequencer_pkg.sv
// Shared definitions for the bus scenario sequencer: FSM states, slave ids,
// scenario code limits and the per-master scenario table.
package bus_scenario_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] SLV_NONE = 2'd0;
  localparam logic [1:0] SLV_S1   = 2'd1;
  localparam logic [1:0] SLV_S2   = 2'd2;
  localparam logic [1:0] SLV_S3   = 2'd3;

  localparam int unsigned SCEN_NONE = 0;
  localparam int unsigned SCEN_MAX  = 9;

  localparam logic [11:0] SCEN_ADDR  = 12'h555;
  localparam logic [7:0]  SCEN_DATA  = 8'hAA;
  localparam logic [3:0]  SCEN_BURST = 4'hF;

  typedef struct packed {
    logic       en;
    logic       wr;
    logic [1:0] slave;
  } scen_entry_t;

  function automatic scen_entry_t mk_entry(input logic wr, input logic [1:0] slave);
    scen_entry_t e;
    e.en    = 1'b1;
    e.wr    = wr;
    e.slave = slave;
    return e;
  endfunction

  // Only masters 0 and 1 ever appear in the table; higher indices stay disabled.
  function automatic scen_entry_t scen_lookup(input logic [7:0] code, input int idx);
    scen_entry_t m0;
    scen_entry_t m1;
    m0 = '0;
    m1 = '0;
    case (code)
      8'd1: m0 = mk_entry(1'b1, SLV_S2);
      8'd2: begin m0 = mk_entry(1'b0, SLV_S2); m1 = mk_entry(1'b1, SLV_S2); end
      8'd3: begin m0 = mk_entry(1'b0, SLV_S2); m1 = mk_entry(1'b1, SLV_S1); end
      8'd4: begin m0 = mk_entry(1'b0, SLV_S2); m1 = mk_entry(1'b0, SLV_S2); end
      8'd5: begin m0 = mk_entry(1'b1, SLV_S2); m1 = mk_entry(1'b1, SLV_S2); end
      8'd6: begin m0 = mk_entry(1'b0, SLV_S1); m1 = mk_entry(1'b0, SLV_S2); end
      8'd7: begin m0 = mk_entry(1'b1, SLV_S1); m1 = mk_entry(1'b0, SLV_S1); end
      8'd8: begin m0 = mk_entry(1'b0, SLV_S1); m1 = mk_entry(1'b1, SLV_S1); end
      8'd9: begin m0 = mk_entry(1'b1, SLV_S2); m1 = mk_entry(1'b1, SLV_S1); end
      default: ;
    endcase
    if (idx == 0)      return m0;
    else if (idx == 1) return m1;
    else               return '0;
  endfunction

endpackage

// File: rtl/bus_scenario_sequencer_rom.sv
// Registered scenario table: captures the per-master command set for a
// scenario code on the launch edge and holds it for the whole run.
module bus_scenario_rom
  import bus_scenario_sequencer_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int SLV_WIDTH   = 2,
  parameter int BURST_WIDTH = 4,
  parameter int SCEN_WIDTH  = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  logic [SCEN_WIDTH-1:0]            scenario,
  output logic [N_MASTERS-1:0]             en,
  output logic [N_MASTERS-1:0]             wr,
  output logic [N_MASTERS*SLV_WIDTH-1:0]   slave,
  output logic [N_MASTERS*ADDR_WIDTH-1:0]  addr,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  data,
  output logic [N_MASTERS*BURST_WIDTH-1:0] burst,
  output logic                             illegal
);

  logic                             illegal_d;
  logic [7:0]                       code;
  scen_entry_t                      entry;
  logic [N_MASTERS-1:0]             en_d;
  logic [N_MASTERS-1:0]             wr_d;
  logic [N_MASTERS*SLV_WIDTH-1:0]   slave_d;
  logic [N_MASTERS*ADDR_WIDTH-1:0]  addr_d;
  logic [N_MASTERS*DATA_WIDTH-1:0]  data_d;
  logic [N_MASTERS*BURST_WIDTH-1:0] burst_d;

  assign illegal_d = 32'(scenario) > SCEN_MAX;
  // Illegal codes are forced to 0 so wide codes cannot alias onto a table row.
  assign code      = illegal_d ? 8'd0 : 8'(scenario);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    entry   = '0;
    en_d    = '0;
    wr_d    = '0;
    slave_d = '0;
    addr_d  = '0;
    data_d  = '0;
    burst_d = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      entry   = scen_lookup(code, i);
      en_d[i] = entry.en;
      wr_d[i] = entry.wr;
      slave_d[i*SLV_WIDTH +: SLV_WIDTH] = SLV_WIDTH'(entry.slave);
      if (entry.en) begin
        addr_d[i*ADDR_WIDTH +: ADDR_WIDTH]    = ADDR_WIDTH'(SCEN_ADDR);
        data_d[i*DATA_WIDTH +: DATA_WIDTH]    = DATA_WIDTH'(SCEN_DATA);
        burst_d[i*BURST_WIDTH +: BURST_WIDTH] = BURST_WIDTH'(SCEN_BURST);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= '0;
      wr      <= '0;
      slave   <= '0;
      addr    <= '0;
      data    <= '0;
      burst   <= '0;
      illegal <= 1'b0;
    end else if (load) begin
      en      <= en_d;
      wr      <= wr_d;
      slave   <= slave_d;
      addr    <= addr_d;
      data    <= data_d;
      burst   <= burst_d;
      illegal <= illegal_d;
    end
  end

endmodule

// File: rtl/bus_scenario_sequencer.sv
// Scenario engine: launches a table-driven set of master bursts, tracks
// completion, timeout and read-data mismatch, and reports one status snapshot.
module bus_scenario_sequencer
  import bus_scenario_sequencer_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int SLV_WIDTH   = 2,
  parameter int BURST_WIDTH = 4,
  parameter int SCEN_WIDTH  = 5,
  parameter int CONCURRENT  = 1,
  parameter int TIMEOUT     = 16000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [SCEN_WIDTH-1:0]            scenario,
  output logic [N_MASTERS-1:0]             m_req,
  output logic [N_MASTERS-1:0]             m_wr,
  output logic [N_MASTERS*SLV_WIDTH-1:0]   m_slave,
  output logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  output logic [N_MASTERS*BURST_WIDTH-1:0] m_burst,
  input  logic [N_MASTERS-1:0]             m_done,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_rdata,
  output logic                             busy,
  output logic                             done,
  output logic                             err_timeout,
  output logic                             err_scen,
  output logic [N_MASTERS-1:0]             rd_mismatch
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                          state;
  state_t                          state_next;
  logic                            start_q;
  logic                            launch;
  logic [N_MASTERS-1:0]            pending;
  logic [N_MASTERS-1:0]            serviced;
  logic [N_MASTERS-1:0]            remaining;
  logic [N_MASTERS-1:0]            issue_sel;
  logic [N_MASTERS-1:0]            retire;
  logic [N_MASTERS-1:0]            pending_left;
  logic [N_MASTERS-1:0]            mismatch;
  logic [CNT_W-1:0]                wait_cnt;
  logic                            timed_out;
  logic [N_MASTERS-1:0]            rom_en;
  logic [N_MASTERS-1:0]            rom_wr;
  logic [N_MASTERS*DATA_WIDTH-1:0] rom_data;
  logic                            rom_illegal;

  // The table row is captured on the launch edge, so LOAD already sees it.
  bus_scenario_rom #(
    .N_MASTERS  (N_MASTERS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SLV_WIDTH  (SLV_WIDTH),
    .BURST_WIDTH(BURST_WIDTH),
    .SCEN_WIDTH (SCEN_WIDTH)
  ) u_rom (
    .clk     (clk),
    .reset   (reset),
    .load    (launch),
    .scenario(scenario),
    .en      (rom_en),
    .wr      (rom_wr),
    .slave   (m_slave),
    .addr    (m_addr),
    .data    (rom_data),
    .burst   (m_burst),
    .illegal (rom_illegal)
  );

  assign m_wr    = rom_wr;
  assign m_wdata = rom_data;

  assign launch       = (state == S_IDLE) && start && !start_q;
  assign remaining    = rom_en & ~serviced;
  // Sequential mode picks the lowest unserviced master (x & -x).
  assign issue_sel    = (CONCURRENT != 0) ? remaining : (remaining & (~remaining + N_MASTERS'(1)));
  assign retire       = (state == S_WAIT) ? (m_done & pending) : '0;
  assign pending_left = pending & ~retire;
  assign timed_out    = (state == S_WAIT) && (pending_left != '0) &&
                        (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (retire[i] && !rom_wr[i] &&
          (m_rdata[i*DATA_WIDTH +: DATA_WIDTH] != rom_data[i*DATA_WIDTH +: DATA_WIDTH]))
        mismatch[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (launch) state_next = S_LOAD;
      S_LOAD:  state_next = (rom_illegal || rom_en == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (timed_out)                state_next = S_DONE;
        else if (pending_left == '0)  state_next = (remaining != '0) ? S_ISSUE : S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q     <= 1'b0;
      m_req       <= '0;
      pending     <= '0;
      serviced    <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      err_scen    <= 1'b0;
      rd_mismatch <= '0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: if (launch) begin
          serviced    <= '0;
          pending     <= '0;
          err_timeout <= 1'b0;
          err_scen    <= 1'b0;
          rd_mismatch <= '0;
        end
        S_LOAD: err_scen <= rom_illegal;
        S_ISSUE: begin
          m_req    <= m_req | issue_sel;
          pending  <= issue_sel;
          serviced <= serviced | issue_sel;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          rd_mismatch <= rd_mismatch | mismatch;
          if (timed_out) begin
            m_req       <= '0;
            pending     <= '0;
            err_timeout <= 1'b1;
          end else begin
            m_req    <= m_req & ~retire;
            pending  <= pending_left;
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
